// File: rtl/trigger_sequence_engine.sv
// trigger_sequence_engine
// Qualifies an ordered sequence of trigger edges, each taken from a selectable
// source with its own polarity. Optional min/max windows between stages apply.
// One capture trigger is issued per arming.
// Optional feature: define TRIGGER_SEQ_AUTO_REARM_EN to add I_auto_rearm and
// O_seq_count (re-arm after each completed sequence, count completions).
//
// state      | meaning
// IDLE       | disarmed; waiting for armed_and_ready
// WAIT_FIRST | armed; waiting for the stage-0 edge
// WAIT_NEXT  | waiting for the edge of stage O_stage; gap counter running
// DONE       | trigger issued; holding until disarmed
module trigger_sequence_engine #(
    parameter int pNUM_INPUTS    = 4,
    parameter int pNUM_STAGES    = 4,
    parameter int pCOUNTER_WIDTH = 16,
    parameter int pSEL_WIDTH     = 2,
    parameter int pSTAGE_WIDTH   = 2
) (
    input  logic                                      adc_clk,
    input  logic                                      reset_n,
    input  logic                                      armed_and_ready,
    input  logic                                      I_bypass,
    input  logic [pNUM_INPUTS-1:0]                    I_trigger,
    input  logic [pNUM_STAGES*pSEL_WIDTH-1:0]         I_stage_sel,
    input  logic [pNUM_STAGES-1:0]                    I_stage_falling,
    input  logic [(pNUM_STAGES-1)*pCOUNTER_WIDTH-1:0] I_min_wait,
    input  logic [(pNUM_STAGES-1)*pCOUNTER_WIDTH-1:0] I_max_wait,
    input  logic [pSTAGE_WIDTH-1:0]                   I_last_stage,
    input  logic                                      I_restart_on_early,
`ifdef TRIGGER_SEQ_AUTO_REARM_EN
    input  logic                                      I_auto_rearm,
    output logic [7:0]                                O_seq_count,
`endif
    output logic                                      O_trigger,
    output logic [pSTAGE_WIDTH-1:0]                   O_stage,
    output logic                                      O_too_early,
    output logic                                      O_too_late
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        WAIT_NEXT  = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam logic [pSTAGE_WIDTH-1:0]   LAST_MAX = pSTAGE_WIDTH'(pNUM_STAGES - 1);
    localparam logic [pCOUNTER_WIDTH-1:0] CNT_ONE  = pCOUNTER_WIDTH'(1);
    localparam logic [pCOUNTER_WIDTH-1:0] CNT_SAT  = '1;

    state_t                      state_q, state_nxt;
    logic [pSTAGE_WIDTH-1:0]     stage_q, stage_nxt;
    logic [pCOUNTER_WIDTH-1:0]   counter_q, counter_nxt;
    logic                        too_early_q, too_early_nxt;
    logic                        too_late_q, too_late_nxt;
    logic                        trig_q, trig_nxt;

    logic [pNUM_INPUTS-1:0]      sync_s1, sync_s2, sync_s3;
    logic [pNUM_STAGES-1:0]      stage_edge;
    logic                        cur_edge;
    logic [pCOUNTER_WIDTH-1:0]   cur_min, cur_max;
    logic [pCOUNTER_WIDTH-1:0]   counter_inc;
    logic [pSTAGE_WIDTH-1:0]     last_eff;
    logic                        is_early, is_accept, is_timeout;
    logic                        bypass_raw;
    logic                        auto_rearm;

`ifdef TRIGGER_SEQ_AUTO_REARM_EN
    logic [7:0]                  seq_count_q;

    assign auto_rearm  = I_auto_rearm;
    assign O_seq_count = seq_count_q;
`else
    assign auto_rearm  = 1'b0;
`endif

    // Two-flop synchroniser per source plus a history flop for edge detection.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
            sync_s3 <= '0;
        end else begin
            sync_s1 <= I_trigger;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
        end
    end

    // Per-stage edge: selected source, selected polarity.
    always_comb begin
        stage_edge = '0;
        for (int k = 0; k < pNUM_STAGES; k++) begin
            for (int i = 0; i < pNUM_INPUTS; i++) begin
                if (I_stage_sel[k*pSEL_WIDTH +: pSEL_WIDTH] == pSEL_WIDTH'(i)) begin
                    stage_edge[k] = I_stage_falling[k] ? (~sync_s2[i] &  sync_s3[i])
                                                       : ( sync_s2[i] & ~sync_s3[i]);
                end
            end
        end
    end

    // Edge and window limits that apply to the stage currently awaited.
    always_comb begin
        cur_edge = 1'b0;
        cur_min  = '0;
        cur_max  = '0;
        for (int k = 0; k < pNUM_STAGES; k++) begin
            if (stage_q == pSTAGE_WIDTH'(k)) begin
                cur_edge = stage_edge[k];
            end
        end
        for (int k = 1; k < pNUM_STAGES; k++) begin
            if (stage_q == pSTAGE_WIDTH'(k)) begin
                cur_min = I_min_wait[(k-1)*pCOUNTER_WIDTH +: pCOUNTER_WIDTH];
                cur_max = I_max_wait[(k-1)*pCOUNTER_WIDTH +: pCOUNTER_WIDTH];
            end
        end
    end

    // Raw stage-0 source for the bypass path; no synchroniser latency.
    always_comb begin
        bypass_raw = 1'b0;
        for (int i = 0; i < pNUM_INPUTS; i++) begin
            if (I_stage_sel[pSEL_WIDTH-1:0] == pSEL_WIDTH'(i)) begin
                bypass_raw = I_trigger[i];
            end
        end
    end

    assign last_eff    = (I_last_stage > LAST_MAX) ? LAST_MAX : I_last_stage;
    assign counter_inc = (counter_q == CNT_SAT) ? counter_q : counter_q + 1'b1;
    assign is_early    = cur_edge && (cur_min != '0) && (counter_q < cur_min);
    assign is_accept   = cur_edge && !is_early;
    assign is_timeout  = (cur_max != '0) && (counter_q == cur_max);

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_nxt     = state_q;
        stage_nxt     = stage_q;
        counter_nxt   = counter_q;
        too_early_nxt = too_early_q;
        too_late_nxt  = too_late_q;
        trig_nxt      = 1'b0;

        if (!armed_and_ready) begin
            // Disarm wins everywhere; sticky flags are kept for inspection.
            state_nxt   = IDLE;
            stage_nxt   = '0;
            counter_nxt = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_nxt     = WAIT_FIRST;
                    stage_nxt     = '0;
                    counter_nxt   = '0;
                    too_early_nxt = 1'b0;
                    too_late_nxt  = 1'b0;
                end
                WAIT_FIRST: begin
                    if (cur_edge) begin
                        counter_nxt = CNT_ONE;
                        if (last_eff == '0) begin
                            trig_nxt  = 1'b1;
                            state_nxt = auto_rearm ? WAIT_FIRST : DONE;
                        end else begin
                            stage_nxt = pSTAGE_WIDTH'(1);
                            state_nxt = WAIT_NEXT;
                        end
                    end
                end
                WAIT_NEXT: begin
                    counter_nxt = counter_inc;
                    if (is_accept) begin
                        // An accepted edge beats a timeout in the same cycle.
                        counter_nxt = CNT_ONE;
                        if (stage_q >= last_eff) begin
                            trig_nxt = 1'b1;
                            if (auto_rearm) begin
                                state_nxt = WAIT_FIRST;
                                stage_nxt = '0;
                            end else begin
                                state_nxt = DONE;
                            end
                        end else begin
                            stage_nxt = stage_q + 1'b1;
                        end
                    end else begin
                        if (is_early) begin
                            too_early_nxt = 1'b1;
                        end
                        if (is_early && I_restart_on_early) begin
                            state_nxt   = WAIT_FIRST;
                            stage_nxt   = '0;
                            counter_nxt = '0;
                        end else if (is_timeout) begin
                            too_late_nxt = 1'b1;
                            state_nxt    = WAIT_FIRST;
                            stage_nxt    = '0;
                            counter_nxt  = '0;
                        end
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Sequencer state register and registered outputs.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            counter_q   <= '0;
            too_early_q <= 1'b0;
            too_late_q  <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            stage_q     <= stage_nxt;
            counter_q   <= counter_nxt;
            too_early_q <= too_early_nxt;
            too_late_q  <= too_late_nxt;
            trig_q      <= trig_nxt;
        end
    end

`ifdef TRIGGER_SEQ_AUTO_REARM_EN
    // Completed-sequence counter; trig_nxt is high exactly on completion.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_count_q <= '0;
        end else if (armed_and_ready && (state_q == IDLE)) begin
            seq_count_q <= '0;
        end else if (trig_nxt && (seq_count_q != 8'hFF)) begin
            seq_count_q <= seq_count_q + 8'd1;
        end
    end
`endif

    assign O_trigger   = I_bypass ? bypass_raw : trig_q;
    assign O_stage     = stage_q;
    assign O_too_early = too_early_q;
    assign O_too_late  = too_late_q;

endmodule

// File: tb/tb_trigger_sequence_engine.sv
// Bench for trigger_sequence_engine: directed test-plan sessions plus random
// sessions, checked against a timestamp-based reference model via a scoreboard.
`timescale 1ns/1ps
module tb_trigger_sequence_engine;

    localparam int NI = 4;
    localparam int NS = 4;
    localparam int CW = 16;
    localparam int SW = 2;
    localparam int TW = 2;

    logic                   adc_clk = 1'b0;
    logic                   reset_n = 1'b1;
    logic                   armed_and_ready = 1'b0;
    logic                   I_bypass = 1'b0;
    logic [NI-1:0]          I_trigger = '0;
    logic [NS*SW-1:0]       I_stage_sel = '0;
    logic [NS-1:0]          I_stage_falling = '0;
    logic [(NS-1)*CW-1:0]   I_min_wait = '0;
    logic [(NS-1)*CW-1:0]   I_max_wait = '0;
    logic [TW-1:0]          I_last_stage = '0;
    logic                   I_restart_on_early = 1'b0;
    logic                   O_trigger;
    logic [TW-1:0]          O_stage;
    logic                   O_too_early;
    logic                   O_too_late;

    trigger_sequence_engine #(
        .pNUM_INPUTS(NI), .pNUM_STAGES(NS), .pCOUNTER_WIDTH(CW),
        .pSEL_WIDTH(SW), .pSTAGE_WIDTH(TW)
    ) dut (
        .adc_clk(adc_clk), .reset_n(reset_n), .armed_and_ready(armed_and_ready),
        .I_bypass(I_bypass), .I_trigger(I_trigger), .I_stage_sel(I_stage_sel),
        .I_stage_falling(I_stage_falling), .I_min_wait(I_min_wait),
        .I_max_wait(I_max_wait), .I_last_stage(I_last_stage),
        .I_restart_on_early(I_restart_on_early), .O_trigger(O_trigger),
        .O_stage(O_stage), .O_too_early(O_too_early), .O_too_late(O_too_late)
    );

    always #5 adc_clk = ~adc_clk;

    int cyc = 0;
    always @(posedge adc_clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // configuration as the bench sees it
    int c_sel [NS];
    bit c_fall[NS];
    int c_min [NS-1];
    int c_max [NS-1];
    int c_last;
    bit c_restart;
    bit c_bypass;

    // driven input history, indexed by the posedge count at drive time
    logic [NI-1:0] hist [8];
    logic [NI-1:0] drv = '0;

    // reference model: stage awaited, timestamp of last accepted edge
    bit m_session = 0, m_fin = 0, m_early = 0, m_late = 0, m_trig = 0;
    int m_stage = 0, m_tlast = 0;

    typedef struct { int p; int stage; bit early; bit late; bit trig; } exp_t;
    exp_t st_q[$];
    int   trig_q[$];

    typedef struct { int t; int src; } tog_t;
    tog_t sched[$];

    task automatic apply_cfg();
        for (int k = 0; k < NS; k++) begin
            I_stage_sel[k*SW +: SW] = SW'(c_sel[k]);
            I_stage_falling[k]      = c_fall[k];
        end
        for (int k = 0; k < NS-1; k++) begin
            I_min_wait[k*CW +: CW] = CW'(c_min[k]);
            I_max_wait[k*CW +: CW] = CW'(c_max[k]);
        end
        I_last_stage       = TW'(c_last);
        I_restart_on_early = c_restart;
        I_bypass           = c_bypass;
    endtask

    // Edge of stage k as the DUT sees it at posedge p: the driven waveform
    // reaches the edge detector three posedges after it is driven.
    function automatic bit edge_m(int k, int p);
        logic [NI-1:0] cur, prv;
        cur = hist[3'(p-3)];
        prv = hist[3'(p-4)];
        if (c_fall[k]) return prv[c_sel[k]] && !cur[c_sel[k]];
        return cur[c_sel[k]] && !prv[c_sel[k]];
    endfunction

    task automatic model_step(input int p, input logic arm);
        int  k, gap, last;
        bit  ev;
        m_trig = 0;
        last = (c_last > NS-1) ? NS-1 : c_last;
        if (!arm) begin
            m_session = 0; m_fin = 0; m_stage = 0;
        end else if (!m_session) begin
            m_session = 1; m_fin = 0; m_stage = 0; m_early = 0; m_late = 0;
        end else if (!m_fin) begin
            k  = m_stage;
            ev = edge_m(k, p);
            if (k == 0) begin
                if (ev) begin
                    if (last == 0) begin m_trig = 1; m_fin = 1; end
                    else begin m_stage = 1; m_tlast = p; end
                end
            end else begin
                gap = p - m_tlast;
                if (ev && (c_min[k-1] == 0 || gap >= c_min[k-1])) begin
                    if (k >= last) begin m_trig = 1; m_fin = 1; end
                    else begin m_stage = k + 1; m_tlast = p; end
                end else begin
                    if (ev) m_early = 1;
                    if (ev && c_restart) m_stage = 0;
                    else if (c_max[k-1] != 0 && gap == c_max[k-1]) begin
                        m_late = 1; m_stage = 0;
                    end
                end
            end
        end
    endtask

    // One cycle of stimulus: drive at negedge, predict the next posedge.
    task automatic step(input logic arm, input logic [NI-1:0] trig);
        exp_t ex;
        int   p;
        @(negedge adc_clk);
        armed_and_ready = arm;
        I_trigger       = trig;
        apply_cfg();
        p = cyc + 1;
        hist[3'(cyc)] = trig;
        model_step(p, arm);
        ex.p     = p;
        ex.stage = m_stage;
        ex.early = m_early;
        ex.late  = m_late;
        ex.trig  = c_bypass ? trig[c_sel[0]] : m_trig;
        st_q.push_back(ex);
        if (m_trig && !c_bypass) trig_q.push_back(p);
        if (c_bypass) begin
            #1;
            n_cmp++;
            if (O_trigger !== trig[c_sel[0]]) begin
                n_fail++;
                $display("FAIL bypass_comb @%0d: O_trigger=%b expected %b", cyc, O_trigger, trig[c_sel[0]]);
            end
        end
    endtask

    task automatic run_session(input int dur, input bit rnd);
        logic [NI-1:0] v;
        v = drv;
        for (int t = 0; t < dur; t++) begin
            foreach (sched[j]) if (sched[j].t == t) v[sched[j].src] = ~v[sched[j].src];
            if (rnd && $urandom_range(0, 2) == 0) v[$urandom_range(0, NI-1)] ^= 1'b1;
            step(1'b1, v);
        end
        drv = v;
        for (int t = 0; t < 6; t++) step(1'b0, drv);
    endtask

    task automatic prep_directed();
        drv = '0;
        sched.delete();
        for (int t = 0; t < 5; t++) step(1'b0, drv);
    endtask

    task automatic add_tog(input int t, input int src);
        tog_t tg;
        tg.t = t; tg.src = src;
        sched.push_back(tg);
    endtask

    task automatic base_cfg();
        for (int k = 0; k < NS; k++) begin c_sel[k] = k; c_fall[k] = 0; end
        for (int k = 0; k < NS-1; k++) begin c_min[k] = 0; c_max[k] = 0; end
        c_last = NS-1; c_restart = 0; c_bypass = 0;
    endtask

    task automatic rand_cfg();
        for (int k = 0; k < NS; k++) begin
            c_sel[k]  = $urandom_range(0, NI-1);
            c_fall[k] = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < NS-1; k++) begin
            c_min[k] = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
            if ($urandom_range(0, 2) == 0) c_max[k] = 0;
            else c_max[k] = c_min[k] + $urandom_range((c_min[k] == 0) ? 1 : 0, 20);
        end
        c_last    = $urandom_range(0, NS-1);
        c_restart = 1'($urandom_range(0, 1));
        c_bypass  = ($urandom_range(0, 7) == 0);
    endtask

    // Monitor: pops one expectation per posedge and any trigger event.
    initial begin
        exp_t ex;
        int   tt;
        forever begin
            @(posedge adc_clk);
            #1;
            if (st_q.size() > 0) begin
                ex = st_q.pop_front();
                n_cmp++;
                if (ex.p != cyc || O_stage !== TW'(ex.stage) || O_too_early !== ex.early ||
                    O_too_late !== ex.late || O_trigger !== ex.trig) begin
                    n_fail++;
                    $display("FAIL status @%0d: got stage=%0d early=%b late=%b trig=%b, expected stage=%0d early=%b late=%b trig=%b (stamp %0d)",
                             cyc, O_stage, O_too_early, O_too_late, O_trigger,
                             ex.stage, ex.early, ex.late, ex.trig, ex.p);
                end
                if (!I_bypass && O_trigger === 1'b1) begin
                    n_cmp++;
                    if (trig_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL trigger_event @%0d: got pulse, expected none", cyc);
                    end else begin
                        tt = trig_q.pop_front();
                        if (tt != cyc) begin
                            n_fail++;
                            $display("FAIL trigger_time: got pulse at %0d, expected at %0d", cyc, tt);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) hist[i] = '0;
        base_cfg();
        apply_cfg();
        #1 reset_n = 1'b0;
        #2;
        n_cmp += 4;
        if (O_trigger !== 1'b0)   begin n_fail++; $display("FAIL reset_trigger: got %b expected 0", O_trigger); end
        if (O_stage !== '0)       begin n_fail++; $display("FAIL reset_stage: got %0d expected 0", O_stage); end
        if (O_too_early !== 1'b0) begin n_fail++; $display("FAIL reset_early: got %b expected 0", O_too_early); end
        if (O_too_late !== 1'b0)  begin n_fail++; $display("FAIL reset_late: got %b expected 0", O_too_late); end
        #19 reset_n = 1'b1;

        // 3-stage rising sequence, completes
        base_cfg();
        c_min[0] = 10; c_min[1] = 5; c_max[0] = 100; c_max[1] = 50; c_last = 2; c_restart = 1;
        prep_directed();
        add_tog(5, 0); add_tog(25, 1); add_tog(35, 2);
        run_session(60, 0);

        // early stage-1 edge with restart
        prep_directed();
        add_tog(5, 0); add_tog(9, 1);
        run_session(40, 0);

        // early edge ignored, later stage-1 edge at gap 12 completes
        c_restart = 0;
        prep_directed();
        add_tog(5, 0); add_tog(9, 1); add_tog(11, 1); add_tog(17, 1); add_tog(25, 2);
        run_session(50, 0);

        // timeout at max 8, then an edge landing exactly on max
        base_cfg();
        c_max[0] = 8; c_last = 1;
        prep_directed();
        add_tog(5, 0);
        run_session(30, 0);
        prep_directed();
        add_tog(5, 0); add_tog(13, 1);
        run_session(30, 0);

        // single falling stage on source 3; one trigger per arming
        base_cfg();
        c_last = 0; c_fall[0] = 1; c_sel[0] = 3;
        prep_directed();
        add_tog(2, 3); add_tog(10, 3); add_tog(20, 3); add_tog(25, 3);
        run_session(40, 0);
        prep_directed();
        add_tog(2, 3); add_tog(10, 3);
        run_session(25, 0);

        // disarm while at stage 2 of 4
        base_cfg();
        prep_directed();
        add_tog(5, 0); add_tog(10, 1);
        run_session(20, 0);

        // bypass with random activity
        base_cfg();
        c_bypass = 1; c_last = 1;
        prep_directed();
        run_session(60, 1);

        // random sessions
        sched.delete();
        for (int s = 0; s < 150; s++) begin
            rand_cfg();
            run_session($urandom_range(20, 150), 1);
        end

        @(posedge adc_clk);
        #2;
        n_cmp++;
        if (st_q.size() != 0 || trig_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d status / %0d triggers left, expected 0 / 0", st_q.size(), trig_q.size());
        end

        // async reset in the middle of WAIT_NEXT
        base_cfg();
        apply_cfg();
        I_trigger = '0;
        repeat (5) @(negedge adc_clk);
        armed_and_ready = 1'b1;
        repeat (3) @(negedge adc_clk);
        I_trigger[0] = 1'b1;
        repeat (6) @(negedge adc_clk);
        @(posedge adc_clk);
        #1;
        n_cmp++;
        if (O_stage !== TW'(1)) begin
            n_fail++;
            $display("FAIL pre_reset_stage: got %0d expected 1", O_stage);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({O_trigger, O_stage, O_too_early, O_too_late} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got trig=%b stage=%0d early=%b late=%b expected all 0",
                     O_trigger, O_stage, O_too_early, O_too_late);
        end
        armed_and_ready = 1'b0;
        #20 reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/trigger_sequence_engine.md
Name: trigger_sequence_engine

Overview:
- Next-generation trigger sequencer for the ADC capture path. Sits between the trigger-source mux and the capture trigger input.
- Qualifies an ordered sequence of up to pNUM_STAGES edges. Each stage is taken from any of pNUM_INPUTS trigger sources, with a per-stage edge polarity.
- Inter-stage min/max windows apply; a window value of 0 disables that limit.
- Issues one capture trigger per arming, and reports per-stage progress and sticky early/late error flags.

Parameters:
- pNUM_INPUTS, 4, number of raw trigger sources (2..16).
- pNUM_STAGES, 4, number of sequence stages (2..16).
- pCOUNTER_WIDTH, 16, width of the inter-stage cycle counter and of each window value.
- pSEL_WIDTH, 2, width of a source select; must satisfy 2^pSEL_WIDTH >= pNUM_INPUTS.
- pSTAGE_WIDTH, 2, width of a stage index; must satisfy 2^pSTAGE_WIDTH >= pNUM_STAGES.

Ports:
- adc_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- armed_and_ready  in  1  level; the sequencer runs while high.
- I_bypass  in  1  when set, drives the selected raw stage-0 source straight to O_trigger.
- I_trigger  in  pNUM_INPUTS  raw trigger sources, asynchronous to adc_clk.
- I_stage_sel  in  pNUM_STAGES*pSEL_WIDTH  source select for each stage; stage k uses slice k.
- I_stage_falling  in  pNUM_STAGES  per-stage polarity: 1 = falling edge, 0 = rising edge.
- I_min_wait  in  (pNUM_STAGES-1)*pCOUNTER_WIDTH  slice k-1 is the minimum gap before stage k; 0 = no minimum.
- I_max_wait  in  (pNUM_STAGES-1)*pCOUNTER_WIDTH  slice k-1 is the maximum gap before stage k; 0 = no maximum.
- I_last_stage  in  pSTAGE_WIDTH  index of the final stage; values above pNUM_STAGES-1 are clamped to it.
- I_restart_on_early  in  1  1 = an early edge aborts the sequence; 0 = an early edge is ignored.
- O_trigger  out  1  one-cycle capture trigger.
- O_stage  out  pSTAGE_WIDTH  stage currently awaited.
- O_too_early  out  1  sticky error flag.
- O_too_late  out  1  sticky error flag.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; counter=0; stage=0; every output 0; all synchroniser and history flops 0.
- Input path:
  - Each input passes through two synchroniser flops (s1, s2) and one history flop (s3).
  - Per-stage edge: rising = s2 & ~s3 of the selected source; falling = ~s2 & s3.
- States:
  - IDLE: armed_and_ready=1 moves to WAIT_FIRST, clears both sticky flags and sets stage=0.
  - WAIT_FIRST: a stage-0 edge sets counter=1.
    - If I_last_stage==0, go to DONE and pulse O_trigger.
    - Otherwise set stage=1 and go to WAIT_NEXT.
  - WAIT_NEXT: counter increments each cycle and saturates at all-ones (no wrap). Let k be the current stage.
    - Edge accepted when counter >= min[k-1] or min[k-1]==0.
    - If the accepted stage k is the final stage, pulse O_trigger and go to DONE. Otherwise set stage=k+1 and counter=1.
    - Edge with counter < min[k-1] (early): set O_too_early.
      - I_restart_on_early=1: go to WAIT_FIRST with stage=0.
      - I_restart_on_early=0: stay in WAIT_NEXT.
    - No accepted edge, max[k-1]!=0 and counter==max[k-1]: set O_too_late, go to WAIT_FIRST with stage=0.
    - An accepted edge in the same cycle as max expiry takes priority over the timeout.
  - DONE: hold until armed_and_ready=0. Only one trigger is issued per arming.
- Disarm: armed_and_ready=0 in any state moves to IDLE on the next edge, with stage=0 and the sticky flags held. A mid-sequence disarm never emits O_trigger.
- O_trigger: registered, high for exactly 1 cycle. Latency: I_trigger first sampled high at edge E0 → O_trigger high after E2 (2 cycles).
- Window arithmetic: counter=N on the cycle that lies N cycles after the previous accepted edge. min/max are compared unsigned at full pCOUNTER_WIDTH.
- Stage-0 edge while already in WAIT_NEXT: ignored unless stage 0 is the same edge as the awaited stage.
- Bypass: O_trigger = raw I_trigger[I_stage_sel[0]] combinationally. The state machine keeps running and the status outputs stay valid.

Optional Feature:
- Macro: TRIGGER_SEQ_AUTO_REARM_EN.
- When defined, two ports are added:
  - I_auto_rearm (in, 1).
  - O_seq_count (out, 8): saturating count of completed sequences; cleared on the IDLE→WAIT_FIRST transition.
- With I_auto_rearm=1, completing the final stage goes to WAIT_FIRST instead of DONE, so multiple triggers are issued per arming.
- When the macro is undefined, neither port exists and the sequencer always goes to DONE.

Test Plan:
- 3-stage rising sequence, sel={0,1,2}, min={10,5}, max={100,50}, last=2. Edges at t=0, t=20, t=30 → one O_trigger pulse 2 cycles after the t=30 edge; both sticky flags 0.
- Same setup, stage-1 edge at gap 4 with restart=1 → O_too_early=1, O_stage returns to 0, no trigger.
- Repeat with restart=0 and a further stage-1 edge at gap 12 → sequence completes.
- max[0]=8 and no stage-1 edge → on the cycle counter reaches 8, O_too_late=1 and O_stage=0. Then a stage-1 edge landing exactly at counter==8 → accepted, no timeout.
- last=0, I_stage_falling[0]=1, source 3 falls → trigger 2 cycles later. A second fall while still armed → no trigger; disarm then re-arm → trigger again.
- Disarm at stage 2 of 4, then reset_n pulsed low mid-WAIT_NEXT → all outputs 0 immediately. I_bypass=1 → O_trigger follows I_trigger[sel0] with no added cycles.
